sum_accumulator: RTL and testbench
==================================

Name: sum_accumulator

Overview:
Downstream consumer of the 2-bit adder stage. Takes the registered SUM_OUT stream and accumulates a fixed window of WINDOW valid samples into a wider running total. It presents the total with a valid/ready handshake and a sticky overflow flag, so results can feed display or check logic without losing data.

Parameters:
IN_W, 2, width of incoming sum (matches adder SUM_OUT)
ACC_W, 8, accumulator/result width; must be >= IN_W
WINDOW, 4, number of accepted samples per result; must be >= 1
CNT_W, $clog2(WINDOW+1), sample counter width (derived)

Ports:
CLK  input  1  system clock, rising edge
RES_X  input  1  asynchronous active-low reset
START  input  1  begin a new accumulation window (level sampled per cycle)
SUM_IN  input  IN_W  sum from adder (SUM_OUT)
SUM_VALID  input  1  SUM_IN holds a sample to accept this cycle
ACC_OUT  output  ACC_W  accumulated result
ACC_VALID  output  1  ACC_OUT/OVF hold a completed result
ACC_READY  input  1  consumer accepts result
OVF  output  1  sticky: carry out of ACC_W occurred during current window
BUSY  output  1  high in ACCUM state
SAMPLE_CNT  output  CNT_W  samples accepted in current window

Behaviour:
- Reset (RES_X=0, async): state=IDLE; ACC_OUT=0, ACC_VALID=0, OVF=0, BUSY=0, SAMPLE_CNT=0. Reset mid-window discards partial sum immediately; no result emitted.
- All outputs registered; state changes on rising CLK.
- States: IDLE, ACCUM, HOLD.
- IDLE: SUM_VALID ignored. START=1 -> ACCUM next cycle; same edge clears ACC_OUT, OVF, SAMPLE_CNT. START=0 -> stay; ACC_OUT keeps last result.
- ACCUM: BUSY=1. Each cycle with SUM_VALID=1: ACC_OUT <= (ACC_OUT + zero-extended SUM_IN) mod 2^ACC_W; carry out of bit ACC_W-1 sets OVF (sticky until next START); SAMPLE_CNT += 1. SUM_VALID=0 cycles: no change (gaps allowed, unbounded). START ignored in ACCUM.
- Window end: the edge accepting sample number WINDOW moves to HOLD. ACC_VALID=1 from the following cycle, ACC_OUT includes that sample (latency 1 cycle after last sample). SAMPLE_CNT reads WINDOW.
- HOLD: BUSY=0. ACC_OUT, OVF, SAMPLE_CNT, ACC_VALID=1 stable until handshake. SUM_VALID samples are dropped (not queued).
- Handshake completes on an edge with ACC_VALID=1 and ACC_READY=1. ACC_VALID falls next cycle.
  - START=0 on that edge -> IDLE.
  - START=1 on that edge -> ACCUM directly (back-to-back); ACC_OUT/OVF/SAMPLE_CNT cleared on that edge. A SUM_VALID on that same edge is not accepted.
- ACC_READY outside HOLD has no effect.
- WINDOW=1: a single accepted sample goes directly to HOLD.

Test Plan:
- Basic: reset, START pulse, SUM_IN 2,3,1,0 with SUM_VALID=1 four consecutive cycles, ACC_READY=1 -> ACC_VALID=1 for exactly 1 cycle, one cycle after 4th sample, with ACC_OUT=6, OVF=0; then IDLE, BUSY=0.
- Gaps: START, samples 3,_,1,_,_,2,3 (_ = SUM_VALID=0) -> ACC_OUT=9 after the 4th valid sample; SAMPLE_CNT steps 1,1,2,2,2,3,4.
- Overflow (ACC_W=3, WINDOW=4): samples 3,3,3,3 -> ACC_OUT=4 (12 mod 8), OVF=1. Next START clears OVF to 0.
- Backpressure: complete window (sum=5) with ACC_READY=0 for 5 cycles while SUM_VALID=1, SUM_IN=3 -> ACC_OUT stays 5, ACC_VALID stays 1; raising ACC_READY drops ACC_VALID next cycle; dropped samples never counted.
- Back-to-back: in HOLD drive ACC_READY=1 and START=1 together -> next cycle BUSY=1, ACC_OUT=0, SAMPLE_CNT=0; second window 1,1,1,1 -> ACC_OUT=4.
- Reset mid-op: after 2 samples (partial sum 4), pulse RES_X=0 asynchronously between edges -> all outputs 0 immediately; after release, no ACC_VALID without a new START.

Source files
------------

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums a fixed window of valid adder samples into a wider
// running total and presents it with a valid/ready handshake and a sticky
// overflow flag.
module sum_accumulator #(
    parameter int unsigned IN_W   = 2,
    parameter int unsigned ACC_W  = 8,
    parameter int unsigned WINDOW = 4,
    parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             CLK,
    input  logic             RES_X,
    input  logic             START,
    input  logic [IN_W-1:0]  SUM_IN,
    input  logic             SUM_VALID,
    output logic [ACC_W-1:0] ACC_OUT,
    output logic             ACC_VALID,
    input  logic             ACC_READY,
    output logic             OVF,
    output logic             BUSY,
    output logic [CNT_W-1:0] SAMPLE_CNT
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    state_t           state;
    logic [SUM_W-1:0] sum_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             last_c;

    // Next accumulation value with carry, and window-end detection
    always_comb begin
        sum_c     = {1'b0, ACC_OUT} + SUM_W'(SUM_IN);
        cnt_inc_c = SAMPLE_CNT + CNT_W'(1);
        last_c    = (cnt_inc_c == CNT_W'(WINDOW));
    end

    // Window FSM with all outputs registered alongside the state
    always_ff @(posedge CLK or negedge RES_X) begin
        if (!RES_X) begin
            state      <= S_IDLE;
            ACC_OUT    <= '0;
            ACC_VALID  <= 1'b0;
            OVF        <= 1'b0;
            BUSY       <= 1'b0;
            SAMPLE_CNT <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state      <= S_ACCUM;
                        BUSY       <= 1'b1;
                        ACC_OUT    <= '0;
                        OVF        <= 1'b0;
                        SAMPLE_CNT <= '0;
                    end
                end
                S_ACCUM: begin
                    if (SUM_VALID) begin
                        ACC_OUT    <= sum_c[ACC_W-1:0];
                        SAMPLE_CNT <= cnt_inc_c;
                        if (sum_c[ACC_W]) begin
                            OVF <= 1'b1;
                        end
                        if (last_c) begin
                            state     <= S_HOLD;
                            BUSY      <= 1'b0;
                            ACC_VALID <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // Result held until accepted; incoming samples are dropped
                    if (ACC_READY) begin
                        ACC_VALID <= 1'b0;
                        if (START) begin
                            state      <= S_ACCUM;
                            BUSY       <= 1'b1;
                            ACC_OUT    <= '0;
                            OVF        <= 1'b0;
                            SAMPLE_CNT <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    BUSY      <= 1'b0;
                    ACC_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default instance with a result
// scoreboard, plus narrow (ACC_W=3) and single-sample (WINDOW=1) instances.
module tb_sum_accumulator;

    logic       clk;
    logic       res_x;

    // Default instance (ACC_W=8, WINDOW=4)
    logic       start, sum_valid, acc_ready;
    logic [1:0] sum_in;
    logic [7:0] acc_out;
    logic       acc_valid, ovf, busy;
    logic [2:0] sample_cnt;

    // Overflow instance (ACC_W=3, WINDOW=4)
    logic       start2, sum_valid2, acc_ready2;
    logic [1:0] sum_in2;
    logic [2:0] acc_out2;
    logic       acc_valid2, ovf2, busy2;
    logic [2:0] sample_cnt2;

    // Single-sample instance (WINDOW=1)
    logic       start3, sum_valid3, acc_ready3;
    logic [1:0] sum_in3;
    logic [7:0] acc_out3;
    logic       acc_valid3, ovf3, busy3;
    logic [0:0] sample_cnt3;

    int errors = 0;
    int checks = 0;

    // Expected results {ovf, acc}, pushed when a window is driven
    logic [8:0] sb[$];

    logic [1:0] b_in [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
    logic       g_v  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] g_in [7] = '{2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3};
    int         g_cnt[7] = '{1, 1, 2, 2, 2, 3, 4};
    int         g_acc[7] = '{3, 3, 4, 4, 4, 6, 9};
    logic [1:0] p_in [4] = '{2'd2, 2'd1, 2'd1, 2'd1};
    logic [1:0] q_in [4] = '{2'd1, 2'd2, 2'd0, 2'd0};

    sum_accumulator dut (
        .CLK(clk), .RES_X(res_x), .START(start), .SUM_IN(sum_in),
        .SUM_VALID(sum_valid), .ACC_OUT(acc_out), .ACC_VALID(acc_valid),
        .ACC_READY(acc_ready), .OVF(ovf), .BUSY(busy), .SAMPLE_CNT(sample_cnt)
    );

    sum_accumulator #(.ACC_W(3)) dut_ovf (
        .CLK(clk), .RES_X(res_x), .START(start2), .SUM_IN(sum_in2),
        .SUM_VALID(sum_valid2), .ACC_OUT(acc_out2), .ACC_VALID(acc_valid2),
        .ACC_READY(acc_ready2), .OVF(ovf2), .BUSY(busy2), .SAMPLE_CNT(sample_cnt2)
    );

    sum_accumulator #(.WINDOW(1)) dut_w1 (
        .CLK(clk), .RES_X(res_x), .START(start3), .SUM_IN(sum_in3),
        .SUM_VALID(sum_valid3), .ACC_OUT(acc_out3), .ACC_VALID(acc_valid3),
        .ACC_READY(acc_ready3), .OVF(ovf3), .BUSY(busy3), .SAMPLE_CNT(sample_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each result at the point it is handed over
    always @(negedge clk) begin
        if (res_x && acc_valid && acc_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected: observed acc=%0d expected no result", acc_out);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                chk("sb_acc", 32'(acc_out), 32'(e[7:0]));
                chk("sb_ovf", 32'(ovf), 32'(e[8]));
            end
        end
    end

    initial begin
        res_x = 1'b0;
        start = 0; sum_valid = 0; acc_ready = 1; sum_in = 0;
        start2 = 0; sum_valid2 = 0; acc_ready2 = 0; sum_in2 = 0;
        start3 = 0; sum_valid3 = 0; acc_ready3 = 1; sum_in3 = 0;
        #1;
        chk("rst_acc", 32'(acc_out), 0);
        chk("rst_valid", 32'(acc_valid), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(sample_cnt), 0);
        step();
        res_x = 1'b1;
        step();

        // Basic window 2,3,1,0 -> 6
        start = 1; step(); start = 0;
        chk("basic_busy", 32'(busy), 1);
        chk("basic_cnt0", 32'(sample_cnt), 0);
        sb.push_back({1'b0, 8'd6});
        for (int i = 0; i < 4; i++) begin
            sum_valid = 1; sum_in = b_in[i];
            step();
            chk("basic_cnt", 32'(sample_cnt), 32'(i + 1));
            if (i < 3) chk("basic_valid_early", 32'(acc_valid), 0);
        end
        sum_valid = 0;
        chk("basic_valid", 32'(acc_valid), 1);
        chk("basic_acc", 32'(acc_out), 6);
        chk("basic_ovf", 32'(ovf), 0);
        chk("basic_busy_hold", 32'(busy), 0);
        step();
        chk("basic_valid_drop", 32'(acc_valid), 0);
        chk("basic_idle_busy", 32'(busy), 0);
        chk("basic_idle_acc", 32'(acc_out), 6);

        // Gaps: 3,_,1,_,_,2,3 -> 9
        start = 1; step(); start = 0;
        sb.push_back({1'b0, 8'd9});
        for (int i = 0; i < 7; i++) begin
            sum_valid = g_v[i]; sum_in = g_in[i];
            step();
            chk("gap_cnt", 32'(sample_cnt), 32'(g_cnt[i]));
            chk("gap_acc", 32'(acc_out), 32'(g_acc[i]));
        end
        sum_valid = 0;
        chk("gap_valid", 32'(acc_valid), 1);
        step();

        // Backpressure: result 5 held while samples of 3 are dropped
        acc_ready = 0;
        start = 1; step(); start = 0;
        sb.push_back({1'b0, 8'd5});
        for (int i = 0; i < 4; i++) begin
            sum_valid = 1; sum_in = p_in[i];
            step();
        end
        sum_in = 3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(acc_valid), 1);
            chk("bp_acc", 32'(acc_out), 5);
            chk("bp_cnt", 32'(sample_cnt), 4);
        end
        sum_valid = 0; acc_ready = 1;
        step();
        chk("bp_valid_drop", 32'(acc_valid), 0);
        chk("bp_acc_kept", 32'(acc_out), 5);

        // Back-to-back: handshake with START restarts immediately
        acc_ready = 0;
        start = 1; step(); start = 0;
        sb.push_back({1'b0, 8'd3});
        for (int i = 0; i < 4; i++) begin
            sum_valid = 1; sum_in = q_in[i];
            step();
        end
        chk("b2b_first_acc", 32'(acc_out), 3);
        acc_ready = 1; start = 1; sum_valid = 1; sum_in = 3;
        step();
        start = 0;
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_acc_clr", 32'(acc_out), 0);
        chk("b2b_cnt_clr", 32'(sample_cnt), 0);
        chk("b2b_valid", 32'(acc_valid), 0);
        sb.push_back({1'b0, 8'd4});
        sum_in = 1;
        for (int i = 0; i < 4; i++) step();
        sum_valid = 0;
        chk("b2b_second_acc", 32'(acc_out), 4);
        chk("b2b_second_valid", 32'(acc_valid), 1);
        step();
        chk("b2b_done", 32'(acc_valid), 0);

        // Overflow on narrow accumulator: 3,3,3,3 -> 12 mod 8 = 4
        start2 = 1; step(); start2 = 0;
        sum_valid2 = 1; sum_in2 = 3;
        step(); step();
        chk("ovf_pre", 32'(ovf2), 0);
        step();
        chk("ovf_set", 32'(ovf2), 1);
        step();
        sum_valid2 = 0;
        chk("ovf_acc", 32'(acc_out2), 4);
        chk("ovf_sticky", 32'(ovf2), 1);
        chk("ovf_valid", 32'(acc_valid2), 1);
        acc_ready2 = 1; start2 = 1;
        step();
        start2 = 0; acc_ready2 = 0;
        chk("ovf_clear", 32'(ovf2), 0);
        chk("ovf_restart_busy", 32'(busy2), 1);

        // WINDOW=1: one sample goes straight to HOLD
        start3 = 1; step(); start3 = 0;
        sum_valid3 = 1; sum_in3 = 2;
        step();
        sum_valid3 = 0;
        chk("w1_valid", 32'(acc_valid3), 1);
        chk("w1_acc", 32'(acc_out3), 2);
        chk("w1_cnt", 32'(sample_cnt3), 1);
        chk("w1_busy", 32'(busy3), 0);
        step();
        chk("w1_valid_drop", 32'(acc_valid3), 0);

        // Reset mid-window discards the partial sum
        start = 1; step(); start = 0;
        sum_valid = 1; sum_in = 2;
        step(); step();
        sum_valid = 0;
        chk("mid_partial", 32'(acc_out), 4);
        #3 res_x = 1'b0;
        #1;
        chk("mid_rst_acc", 32'(acc_out), 0);
        chk("mid_rst_cnt", 32'(sample_cnt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(acc_valid), 0);
        step();
        res_x = 1'b1;
        sum_valid = 1; sum_in = 3;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_valid", 32'(acc_valid), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        sum_valid = 0;

        chk("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
